// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_fetch_unit_pkg : shared constants and state encoding for fetch stage   |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package pc_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    SPEC = 1'b1
  } fetch_state_t;

endpackage : pc_fetch_unit_pkg
`default_nettype wire

// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_fetch_unit_if : control, memory and IF/ID signals of the fetch stage   |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface pc_fetch_unit_if;

  logic        Stall;
  logic        BranchAddress_mux;
  logic [31:0] BranchTarget;
  logic        AdderMux;
  logic        Flush;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic [31:0] InstrMem;
  logic [31:0] PC;
  logic [31:0] Instr_id;
  logic [31:0] PC_id;
  logic        Valid_id;
  logic        Speculating;

  modport master (
    output Stall, BranchAddress_mux, BranchTarget, AdderMux, Flush,
           Jump, JumpTarget, InstrMem,
    input  PC, Instr_id, PC_id, Valid_id, Speculating
  );

  modport slave (
    input  Stall, BranchAddress_mux, BranchTarget, AdderMux, Flush,
           Jump, JumpTarget, InstrMem,
    output PC, Instr_id, PC_id, Valid_id, Speculating
  );

endinterface : pc_fetch_unit_if
`default_nettype wire

// File: rtl/pc_fetch_unit_pc_next_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_next_mux : combinational next-PC selection (recover > stall > branch   |
// | > jump > sequential).                                 rev 1.0             |
// +--------------------------------------------------------------------------+
module pc_next_mux
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] recoverAddr,
  input  logic [31:0] branchTarget,
  input  logic [31:0] jumpTarget,
  input  logic        recoverEn,
  input  logic        stall,
  input  logic        branchSel,
  input  logic        jump,
  output logic [31:0] nextPc
);

  always_comb begin
    nextPc = pc + PC_STEP;  // natural 32-bit wrap
    if (recoverEn)      nextPc = recoverAddr;
    else if (stall)     nextPc = pc;
    else if (branchSel) nextPc = branchTarget;
    else if (jump)      nextPc = jumpTarget;
  end

endmodule : pc_next_mux
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_fetch_unit : PC register, IF/ID register and branch-speculation FSM    |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  pc_fetch_unit_if.slave    bus
);

  fetch_state_t r_state, w_stateNext;
  logic [1:0]   r_count, w_countNext;
  logic [31:0]  r_recoverAddr, w_recoverNext;
  logic [31:0]  r_pc, w_nextPc;
  logic [31:0]  r_instrId;
  logic [31:0]  r_pcId;
  logic         r_validId;
  logic         w_recoverEn;

  // A recovery request only means something while a prediction is outstanding
  assign w_recoverEn = bus.AdderMux && (r_state == SPEC);

  pc_next_mux u_next_mux (
    .pc           (r_pc),
    .recoverAddr  (r_recoverAddr),
    .branchTarget (bus.BranchTarget),
    .jumpTarget   (bus.JumpTarget),
    .recoverEn    (w_recoverEn),
    .stall        (bus.Stall),
    .branchSel    (bus.BranchAddress_mux),
    .jump         (bus.Jump),
    .nextPc       (w_nextPc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RUN;
      r_count       <= 2'd0;
      r_recoverAddr <= 32'd0;
    end else begin
      r_state       <= w_stateNext;
      r_count       <= w_countNext;
      r_recoverAddr <= w_recoverNext;
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_countNext   = r_count;
    w_recoverNext = r_recoverAddr;
    if (w_recoverEn) begin
      w_stateNext = RUN;
      w_countNext = 2'd0;
    end else if (!bus.Stall) begin
      if (bus.BranchAddress_mux) begin
        // The branch sits in ID, so its fall-through is PC_id + 4
        w_stateNext   = SPEC;
        w_countNext   = 2'd0;
        w_recoverNext = r_pcId + PC_STEP;
      end else if (r_state == SPEC) begin
        if (r_count == 2'd1) begin
          w_stateNext = RUN;
          w_countNext = 2'd0;
        end else begin
          w_countNext = r_count + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_instrId <= NOP_INSTR;
      r_pcId    <= 32'd0;
      r_validId <= 1'b0;
    end else begin
      r_pc <= w_nextPc;
      if (w_recoverEn || bus.Flush) begin
        r_instrId <= NOP_INSTR;
        r_validId <= 1'b0;
      end else if (!bus.Stall) begin
        r_instrId <= bus.InstrMem;
        r_pcId    <= r_pc;
        r_validId <= 1'b1;
      end
    end
  end

  assign bus.PC          = r_pc;
  assign bus.Instr_id    = r_instrId;
  assign bus.PC_id       = r_pcId;
  assign bus.Valid_id    = r_validId;
  assign bus.Speculating = (r_state == SPEC);

endmodule : pc_fetch_unit
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pc_fetch_unit : directed bench; instruction memory returns ~PC         |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_pc_fetch_unit;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  pc_fetch_unit_if bus ();

  pc_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.InstrMem = ~bus.PC;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic clearCtl();
    bus.Stall             = 1'b0;
    bus.BranchAddress_mux = 1'b0;
    bus.BranchTarget      = 32'd0;
    bus.AdderMux          = 1'b0;
    bus.Flush             = 1'b0;
    bus.Jump              = 1'b0;
    bus.JumpTarget        = 32'd0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    clearCtl();
    tick();
    tick();
    check("rst_pc", bus.PC, 32'h0);
    check("rst_instr", bus.Instr_id, 32'h0);
    check("rst_pcid", bus.PC_id, 32'h0);
    check("rst_valid", {31'd0, bus.Valid_id}, 32'd0);
    check("rst_spec", {31'd0, bus.Speculating}, 32'd0);

    // Free run from reset
    reset = 1'b0;
    tick();
    check("run1_pc", bus.PC, 32'h4);
    check("run1_pcid", bus.PC_id, 32'h0);
    check("run1_instr", bus.Instr_id, 32'hFFFF_FFFF);
    check("run1_valid", {31'd0, bus.Valid_id}, 32'd1);
    tick();
    check("run2_pc", bus.PC, 32'h8);
    check("run2_pcid", bus.PC_id, 32'h4);
    tick();
    check("run3_pc", bus.PC, 32'hC);
    check("run3_pcid", bus.PC_id, 32'h8);

    // Jump to 0x100, then mispredicted branch with recovery
    bus.Jump = 1'b1; bus.JumpTarget = 32'h100;
    tick();
    check("jmp_pc", bus.PC, 32'h100);
    clearCtl();
    tick();
    check("pre_br_pcid", bus.PC_id, 32'h100);
    bus.BranchAddress_mux = 1'b1; bus.BranchTarget = 32'h200;
    tick();
    check("br_pc", bus.PC, 32'h200);
    check("br_spec", {31'd0, bus.Speculating}, 32'd1);
    clearCtl();
    bus.AdderMux = 1'b1; bus.Flush = 1'b1;
    tick();
    check("rec_pc", bus.PC, 32'h104);
    check("rec_valid", {31'd0, bus.Valid_id}, 32'd0);
    check("rec_instr", bus.Instr_id, 32'h0);
    check("rec_spec", {31'd0, bus.Speculating}, 32'd0);
    clearCtl();
    tick();
    check("post_rec_pc", bus.PC, 32'h108);
    check("post_rec_pcid", bus.PC_id, 32'h104);

    // Correct prediction: speculation window closes after two cycles
    bus.BranchAddress_mux = 1'b1; bus.BranchTarget = 32'h200;
    tick();
    check("ok_pc0", bus.PC, 32'h200);
    check("ok_spec0", {31'd0, bus.Speculating}, 32'd1);
    clearCtl();
    tick();
    check("ok_pc1", bus.PC, 32'h204);
    check("ok_spec1", {31'd0, bus.Speculating}, 32'd1);
    tick();
    check("ok_pc2", bus.PC, 32'h208);
    check("ok_spec2", {31'd0, bus.Speculating}, 32'd0);
    bus.AdderMux = 1'b1;
    tick();
    check("run_adder_ign_pc", bus.PC, 32'h20C);
    check("run_adder_ign_valid", {31'd0, bus.Valid_id}, 32'd1);
    clearCtl();

    // Branch beats jump; re-prediction overwrites the saved address
    bus.BranchAddress_mux = 1'b1; bus.BranchTarget = 32'h300;
    bus.Jump = 1'b1; bus.JumpTarget = 32'h500;
    tick();
    check("br_vs_jmp_pc", bus.PC, 32'h300);
    clearCtl();
    bus.Jump = 1'b1; bus.JumpTarget = 32'h500;
    tick();
    check("spec_jmp_pc", bus.PC, 32'h500);
    check("spec_jmp_spec", {31'd0, bus.Speculating}, 32'd1);
    clearCtl();
    bus.BranchAddress_mux = 1'b1; bus.BranchTarget = 32'h600;
    tick();
    check("rebr_pc", bus.PC, 32'h600);
    clearCtl();
    bus.AdderMux = 1'b1;
    tick();
    check("rebr_rec_pc", bus.PC, 32'h304);
    clearCtl();

    // Stall holds everything; recovery overrides stall
    bus.Jump = 1'b1; bus.JumpTarget = 32'h40;
    tick();
    check("stall_setup_pc", bus.PC, 32'h40);
    clearCtl();
    bus.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", bus.PC, 32'h40);
      check("stall_instr", bus.Instr_id, 32'hFFFF_FCFB);
      check("stall_pcid", bus.PC_id, 32'h304);
    end
    clearCtl();
    tick();
    check("unstall_pc", bus.PC, 32'h44);
    bus.BranchAddress_mux = 1'b1; bus.BranchTarget = 32'h80;
    tick();
    check("stall_br_pc", bus.PC, 32'h80);
    clearCtl();
    bus.Stall = 1'b1; bus.AdderMux = 1'b1;
    tick();
    check("stall_rec_pc", bus.PC, 32'h44);
    check("stall_rec_spec", {31'd0, bus.Speculating}, 32'd0);
    clearCtl();
    tick();
    check("sf_pre_pc", bus.PC, 32'h48);
    check("sf_pre_valid", {31'd0, bus.Valid_id}, 32'd1);
    bus.Stall = 1'b1; bus.Flush = 1'b1;
    tick();
    check("sf_pc", bus.PC, 32'h48);
    check("sf_valid", {31'd0, bus.Valid_id}, 32'd0);
    check("sf_instr", bus.Instr_id, 32'h0);
    clearCtl();

    // Wrap at top of address space
    bus.Jump = 1'b1; bus.JumpTarget = 32'hFFFF_FFFC;
    tick();
    check("wrap_pre_pc", bus.PC, 32'hFFFF_FFFC);
    clearCtl();
    tick();
    check("wrap_pc", bus.PC, 32'h0);

    // Reset during speculation discards the saved address
    bus.Jump = 1'b1; bus.JumpTarget = 32'h100;
    tick();
    clearCtl();
    tick();
    bus.BranchAddress_mux = 1'b1; bus.BranchTarget = 32'h200;
    tick();
    check("rs_spec_on", {31'd0, bus.Speculating}, 32'd1);
    clearCtl();
    reset = 1'b1;
    bus.AdderMux = 1'b1;
    tick();
    check("rs_pc", bus.PC, 32'h0);
    check("rs_spec", {31'd0, bus.Speculating}, 32'd0);
    reset = 1'b0;
    tick();
    check("rs_ign_pc", bus.PC, 32'h4);
    check("rs_ign_valid", {31'd0, bus.Valid_id}, 32'd1);
    check("rs_ign_pcid", bus.PC_id, 32'h0);
    clearCtl();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pc_fetch_unit
`default_nettype wire
